// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampled UART receiver.
// The divisor helper rounds to nearest so tick-rate error stays within half a clock.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_NB_DATA      = 8;
    localparam int DEF_NB_STOP      = 16;
    localparam int DEF_BAUD_RATE    = 19200;
    localparam int DEF_CLK_FREQ     = 50_000_000;
    localparam int DEF_OVERSAMPLING = 16;

    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        longint ticks_per_sec;
        ticks_per_sec = longint'(baud) * longint'(os);
        return int'((longint'(clk_freq) + ticks_per_sec / 2) / ticks_per_sec);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Byte-side and serial-side signals of the UART receiver.
// master = receiver, slave = whatever drives the line and consumes bytes.
interface uart_rx_oversampled_if
    import uart_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA
) ();
    logic               i_data;
    logic [NB_DATA-1:0] o_data;
    logic               o_rxdone;
    logic               o_tick;

    modport master (
        input  i_data,
        output o_data,
        output o_rxdone,
        output o_tick
    );

    modport slave (
        output i_data,
        input  o_data,
        input  o_rxdone,
        input  o_tick
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick at BAUD_RATE*OVERSAMPLING.
// Never resynchronised to the data; the receiver FSM absorbs the phase offset.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD_RATE    = DEF_BAUD_RATE,
    parameter int OVERSAMPLING = DEF_OVERSAMPLING
) (
    input  logic clk,
    input  logic i_rst_n,
    output logic o_tick
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLING);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = (count_reg == LAST) ? '0 : count_reg + CW'(1);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign o_tick = (count_reg == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver: finds mid-bit via oversampling ticks, shifts data LSB-first,
// validates the stop bit and publishes the byte with a one-cycle done strobe.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int NB_DATA      = DEF_NB_DATA,
    parameter int NB_STOP      = DEF_NB_STOP,
    parameter int BAUD_RATE    = DEF_BAUD_RATE,
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int OVERSAMPLING = DEF_OVERSAMPLING
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    uart_rx_oversampled_if.master rx
);
    localparam int S_MAX = max_int(OVERSAMPLING, NB_STOP);
    localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int NW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLING / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLING - 1);
    localparam logic [SW-1:0] S_STOP = SW'(NB_STOP - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

    logic tick;

    rx_state_t          state_reg,  state_next;
    logic [SW-1:0]      s_reg,      s_next;
    logic [NW-1:0]      n_reg,      n_next;
    logic [NB_DATA-1:0] shreg_reg,  shreg_next;
    logic [NB_DATA-1:0] data_reg,   data_next;
    logic               rxdone_reg, rxdone_next;

    baud_tick_gen #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD_RATE    (BAUD_RATE),
        .OVERSAMPLING (OVERSAMPLING)
    ) u_baud_tick_gen (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            s_reg      <= '0;
            n_reg      <= '0;
            shreg_reg  <= '0;
            data_reg   <= '0;
            rxdone_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            s_reg      <= s_next;
            n_reg      <= n_next;
            shreg_reg  <= shreg_next;
            data_reg   <= data_next;
            rxdone_reg <= rxdone_next;
        end
    end

    // IDLE reacts every clock so the start edge is caught with one-clock latency;
    // all other states advance only on ticks.
    always_comb begin
        state_next  = state_reg;
        s_next      = s_reg;
        n_next      = n_reg;
        shreg_next  = shreg_reg;
        data_next   = data_reg;
        rxdone_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!rx.i_data) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_reg == S_MID) begin
                        s_next = '0;
                        if (!rx.i_data) begin
                            state_next = DATA;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_reg == S_BIT) begin
                        s_next     = '0;
                        shreg_next = {rx.i_data, shreg_reg[NB_DATA-1:1]};
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + NW'(1);
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_reg == S_STOP) begin
                        // A low stop bit is a framing error: drop the byte silently.
                        if (rx.i_data) begin
                            data_next   = shreg_reg;
                            rxdone_next = 1'b1;
                        end
                        state_next = IDLE;
                        s_next     = '0;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        rx.o_data   = data_reg;
        rx.o_rxdone = rxdone_reg;
        rx.o_tick   = tick;
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled; a reduced clock keeps frames short,
// and a second default-parameter instance confirms the 163-cycle divisor.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
    import uart_pkg::*;

    // 3 MHz / (19200*16) = 9.77 -> rounds to 10 (truncation would give 9)
    localparam int TB_CLK_FREQ = 3_000_000;
    localparam int TB_DIV      = 10;
    localparam int DEF_DIV     = 163;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_oversampled_if #(.NB_DATA(8)) rx_if ();
    uart_rx_oversampled_if #(.NB_DATA(8)) def_if ();

    uart_rx_oversampled #(
        .NB_DATA      (8),
        .NB_STOP      (16),
        .BAUD_RATE    (19200),
        .CLK_FREQ     (TB_CLK_FREQ),
        .OVERSAMPLING (16)
    ) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .rx      (rx_if.master)
    );

    uart_rx_oversampled dut_def (
        .clk     (clk),
        .i_rst_n (rst_n),
        .rx      (def_if.master)
    );

    int total = 0;
    int bad = 0;
    int rx_pulses = 0;
    bit tick_dead = 1'b0;
    logic [7:0] rx_log [0:63];

    always @(negedge clk) begin
        if (rx_if.o_rxdone === 1'b1) begin
            if (rx_pulses < 64) rx_log[rx_pulses] = rx_if.o_data;
            rx_pulses++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Leaves the caller 1 ns after the clock edge on which the DUT consumed a tick.
    task automatic wait_tick();
        int guard;
        guard = 0;
        if (tick_dead) return;
        while (1) begin
            @(negedge clk);
            if (rx_if.o_tick === 1'b1) break;
            guard++;
            if (guard > 4 * TB_DIV) begin
                total++;
                bad++;
                tick_dead = 1'b1;
                $display("FAIL tick_timeout: no tick within %0d cycles, required one every %0d", guard, TB_DIV);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic send_bit(input logic b, input int nticks);
        rx_if.i_data = b;
        wait_ticks(nticks);
    endtask

    // pre_stop: pulse count 7 ticks into the stop bit, one tick before the sample point.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int stop_ticks, output int pre_stop);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        rx_if.i_data = stop_val;
        wait_ticks(7);
        pre_stop = rx_pulses;
        wait_ticks(stop_ticks - 7);
        rx_if.i_data = 1'b1;
    endtask

    task automatic test_reset();
        int c;
        rst_n = 1'b0;
        rx_if.i_data = 1'b1;
        def_if.i_data = 1'b1;
        #18;
        total++; if (rx_if.o_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h want 00", rx_if.o_data); end
        total++; if (rx_if.o_rxdone !== 1'b0) begin bad++; $display("FAIL reset_rxdone: got %b want 0", rx_if.o_rxdone); end
        total++; if (rx_if.o_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", rx_if.o_tick); end
        total++; if (def_if.o_tick !== 1'b0) begin bad++; $display("FAIL reset_tick_def: got %b want 0", def_if.o_tick); end
        total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_reg, IDLE); end
        @(posedge clk);
        #1 rst_n = 1'b1;

        c = 0;
        while (def_if.o_tick !== 1'b1 && c < 400) begin @(negedge clk); c++; end
        c = 0;
        do begin @(negedge clk); c++; end while (def_if.o_tick !== 1'b1 && c < 400);
        total++; if (c !== DEF_DIV) begin bad++; $display("FAIL tick_period_default: got %0d want %0d", c, DEF_DIV); end

        c = 0;
        while (rx_if.o_tick !== 1'b1 && c < 400) begin @(negedge clk); c++; end
        c = 0;
        do begin @(negedge clk); c++; end while (rx_if.o_tick !== 1'b1 && c < 400);
        total++; if (c !== TB_DIV) begin bad++; $display("FAIL tick_period: got %0d want %0d", c, TB_DIV); end
        $display("test_reset: default tick period checked, bench tick period checked");
    endtask

    task automatic test_frame_47();
        int base;
        int pre;
        wait_ticks(10);
        base = rx_pulses;
        send_frame(8'h47, 1'b1, 16, pre);
        total++; if (pre !== base) begin bad++; $display("FAIL frame47_early: pulses %0d before stop sample, want %0d", pre, base); end
        total++; if (rx_pulses !== base + 1) begin bad++; $display("FAIL frame47_count: got %0d pulses want %0d", rx_pulses - base, 1); end
        total++; if (rx_if.o_data !== 8'h47) begin bad++; $display("FAIL frame47_data: got %02h want 47", rx_if.o_data); end
        total++; if (rx_log[base] !== 8'h47) begin bad++; $display("FAIL frame47_strobe_data: got %02h want 47", rx_log[base]); end
        $display("test_frame_47: o_data=%02h pulses=%0d", rx_if.o_data, rx_pulses - base);
    endtask

    task automatic test_back_to_back();
        int base;
        int pre;
        base = rx_pulses;
        send_frame(8'h55, 1'b1, 16, pre);
        send_frame(8'hA3, 1'b1, 16, pre);
        wait_ticks(2);
        total++; if (rx_pulses !== base + 2) begin bad++; $display("FAIL b2b_count: got %0d pulses want 2", rx_pulses - base); end
        total++; if (rx_log[base] !== 8'h55) begin bad++; $display("FAIL b2b_first: got %02h want 55", rx_log[base]); end
        total++; if (rx_log[base+1] !== 8'hA3) begin bad++; $display("FAIL b2b_second: got %02h want a3", rx_log[base+1]); end
        total++; if (rx_if.o_data !== 8'hA3) begin bad++; $display("FAIL b2b_hold: got %02h want a3", rx_if.o_data); end
        $display("test_back_to_back: bytes %02h %02h", rx_log[base], rx_log[base+1]);
    endtask

    task automatic test_glitch();
        int base;
        base = rx_pulses;
        send_bit(1'b0, 4);
        send_bit(1'b1, 12);
        total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL glitch_state: got %0d want %0d", dut.state_reg, IDLE); end
        total++; if (rx_pulses !== base) begin bad++; $display("FAIL glitch_pulse: got %0d pulses want 0", rx_pulses - base); end
        total++; if (rx_if.o_data !== 8'hA3) begin bad++; $display("FAIL glitch_data: got %02h want a3", rx_if.o_data); end
        $display("test_glitch: state=%0d o_data=%02h", dut.state_reg, rx_if.o_data);
    endtask

    task automatic test_framing_error();
        int base;
        int pre;
        base = rx_pulses;
        // Stop held low only 12 ticks so the spurious restart is rejected as a glitch.
        send_frame(8'h3C, 1'b0, 12, pre);
        wait_ticks(10);
        total++; if (rx_pulses !== base) begin bad++; $display("FAIL framing_pulse: got %0d pulses want 0", rx_pulses - base); end
        total++; if (rx_if.o_data !== 8'hA3) begin bad++; $display("FAIL framing_data: got %02h want a3", rx_if.o_data); end
        total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL framing_state: got %0d want %0d", dut.state_reg, IDLE); end
        send_frame(8'h81, 1'b1, 16, pre);
        total++; if (rx_pulses !== base + 1) begin bad++; $display("FAIL after_framing_count: got %0d pulses want 1", rx_pulses - base); end
        total++; if (rx_if.o_data !== 8'h81) begin bad++; $display("FAIL after_framing_data: got %02h want 81", rx_if.o_data); end
        $display("test_framing_error: 3c dropped, then o_data=%02h", rx_if.o_data);
    endtask

    task automatic test_mid_frame_reset();
        int base;
        int pre;
        logic [7:0] pat;
        pat = 8'hB7;
        wait_ticks(4);
        base = rx_pulses;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(pat[i], 16);
        rx_if.i_data = pat[4];
        wait_ticks(4);
        rst_n = 1'b0;
        #2;
        total++; if (rx_if.o_data !== 8'h00) begin bad++; $display("FAIL midreset_data: got %02h want 00", rx_if.o_data); end
        total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL midreset_state: got %0d want %0d", dut.state_reg, IDLE); end
        total++; if (dut.shreg_reg !== 8'h00) begin bad++; $display("FAIL midreset_shreg: got %02h want 00", dut.shreg_reg); end
        rx_if.i_data = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ticks(5);
        total++; if (rx_pulses !== base) begin bad++; $display("FAIL midreset_pulse: got %0d pulses want 0", rx_pulses - base); end
        send_frame(8'hF0, 1'b1, 16, pre);
        total++; if (rx_pulses !== base + 1) begin bad++; $display("FAIL after_reset_count: got %0d pulses want 1", rx_pulses - base); end
        total++; if (rx_if.o_data !== 8'hF0) begin bad++; $display("FAIL after_reset_data: got %02h want f0", rx_if.o_data); end
        $display("test_mid_frame_reset: o_data=%02h", rx_if.o_data);
    endtask

    initial begin
        rx_if.i_data = 1'b1;
        def_if.i_data = 1'b1;
        test_reset();
        test_frame_47();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_mid_frame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
